// File: rtl/led_pkg.sv
// Shared widths, FSM encoding and the address-walk helper for the LED
// pattern address sequencer.
package led_pkg;

   localparam int ADDR_W = 12;
   localparam int LED_W  = 4;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } led_state_e;

   // Result of one address step: the new address and the new effective direction.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              dir;
   } step_res_t;

   // Computes the address that follows cur for one tick.
   // dir_eff: 0 = ascending, 1 = descending.
   // In wrap mode the effective direction is refreshed from dir_in on every tick,
   // while the move itself uses the direction already latched.
   // In bounce mode the direction flips at a bound. The address then steps back
   // inside the range, unless the range holds a single address.
   function automatic step_res_t next_step(
      input logic [ADDR_W-1:0] lo,
      input logic [ADDR_W-1:0] hi,
      input logic [ADDR_W-1:0] cur,
      input logic              dir_eff,
      input logic              dir_in,
      input logic              bounce
   );
      step_res_t r;
      r.addr = cur;
      r.dir  = dir_eff;
      if (bounce) begin
         if (!dir_eff) begin
            if (cur == hi) begin
               r.dir  = 1'b1;
               r.addr = (lo == hi) ? cur : hi - 1'b1;
            end else begin
               r.addr = cur + 1'b1;
            end
         end else begin
            if (cur == lo) begin
               r.dir  = 1'b0;
               r.addr = (lo == hi) ? cur : lo + 1'b1;
            end else begin
               r.addr = cur - 1'b1;
            end
         end
      end else begin
         r.dir = dir_in;
         if (!dir_eff) begin
            r.addr = (cur == hi) ? lo : cur + 1'b1;
         end else begin
            r.addr = (cur == lo) ? hi : cur - 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/led_tick_div.sv
// Prescaler for the address sequencer.
// The counter runs 0..TICK_DIV-1 while run is high and holds its value while
// run is low. tick is high in the cycle where the count is TICK_DIV-1; the
// counter wraps to 0 on the following edge. clr wins over run.
module led_tick_div #(
   parameter int unsigned TICK_DIV = 32'd50000000
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam logic [31:0] LAST = 32'(TICK_DIV - 32'd1);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // Next count: clear, wrap at LAST, advance while running, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_addr_sequencer.sv
// LED pattern address sequencer.
// The block walks a pattern-ROM address between ADDR_LO and ADDR_HI. It takes
// one step every TICK_DIV clocks, in wrap or bounce mode. It captures the ROM
// word into the LED register two cycles after each step.
//
// Control handshake: start and stop are single-cycle pulses that are sampled on
// the rising edge. stop wins over start and pause in the same cycle. start only
// acts in IDLE. pause is a level signal: RUN moves to HOLD while pause is high.
// step is high for exactly one cycle, and that cycle is the first one that shows
// the new addr.
module led_addr_sequencer
   import led_pkg::*;
#(
   parameter int unsigned       TICK_DIV = 32'd50000000,
   parameter logic [ADDR_W-1:0] ADDR_LO  = 12'h000,
   parameter logic [ADDR_W-1:0] ADDR_HI  = 12'hFFF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              dir,
   input  logic              bounce,
   input  logic [LED_W-1:0]  rom_data,
   output logic              rom_en,
   output logic [ADDR_W-1:0] addr,
   output logic              step,
   output logic [LED_W-1:0]  led,
   output logic              busy,
   output led_state_e        state_dbg
);

   led_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dir_eff_q, dir_eff_d;
   logic              step_q, step_d;
   // Step delay pipeline. Stage 0 is set at the addr edge, and the ROM samples
   // addr on the next edge. Stage 1 is therefore high while rom_data is valid,
   // and the LED register captures on the edge after that.
   logic [1:0]        dly_q, dly_d;
   logic [LED_W-1:0]  led_q, led_d;

   logic              presc_clr;
   logic              presc_run;
   logic              tick;
   logic              flush;
   step_res_t         nxt;

   led_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk    (clk),
      .resetn (resetn),
      .clr    (presc_clr),
      .run    (presc_run),
      .tick   (tick)
   );

   // The prescaler only advances in RUN, so HOLD freezes the count.
   assign presc_run = (state_q == RUN);

   // Next state, next address and step generation. All defaults are assigned first.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      dir_eff_d = dir_eff_q;
      step_d    = 1'b0;
      presc_clr = 1'b0;
      flush     = 1'b0;
      nxt       = next_step(ADDR_LO, ADDR_HI, addr_q, dir_eff_q, dir, bounce);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               addr_d    = dir ? ADDR_HI : ADDR_LO;
               dir_eff_d = dir;
               presc_clr = 1'b1;
               step_d    = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else begin
               if (pause) begin
                  state_d = HOLD;
               end
               // A tick that coincides with pause still completes its step.
               if (tick) begin
                  addr_d    = nxt.addr;
                  dir_eff_d = nxt.dir;
                  step_d    = 1'b1;
               end
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            flush   = 1'b1;
         end
      endcase

      // Aborting returns addr to its idle value and restarts the prescaler.
      if (flush) begin
         addr_d    = ADDR_LO;
         presc_clr = 1'b1;
      end
   end

   // Step delay and LED capture. An abort drops any pending capture and blanks the LEDs.
   always_comb begin
      dly_d = {dly_q[0], step_d};
      led_d = led_q;
      if (dly_q[1]) begin
         led_d = rom_data;
      end
      if (flush) begin
         dly_d = '0;
         led_d = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: address, effective direction, step pulse, delay stages, LEDs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         addr_q    <= ADDR_LO;
         dir_eff_q <= 1'b0;
         step_q    <= 1'b0;
         dly_q     <= '0;
         led_q     <= '0;
      end else begin
         addr_q    <= addr_d;
         dir_eff_q <= dir_eff_d;
         step_q    <= step_d;
         dly_q     <= dly_d;
         led_q     <= led_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign rom_en    = busy;
   assign addr      = addr_q;
   assign step      = step_q;
   assign led       = led_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_led_addr_sequencer.sv
// Bench for led_addr_sequencer.
// Instance A walks addresses 0..3 and instance B has a single-address range (5..5).
// Both instances share stimulus and TICK_DIV=4. Each instance has its own
// registered ROM model, which outputs 0 while rom_en is low.
module tb_led_addr_sequencer;
   import led_pkg::*;

   localparam int unsigned TDIV = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn = 1'b0;
   logic start  = 1'b0;
   logic stop   = 1'b0;
   logic pause  = 1'b0;
   logic dir    = 1'b0;
   logic bounce = 1'b0;

   logic [LED_W-1:0]  rom_data_a = '0, rom_data_b = '0;
   logic              rom_en_a, rom_en_b, step_a, step_b, busy_a, busy_b;
   logic [ADDR_W-1:0] addr_a, addr_b;
   logic [LED_W-1:0]  led_a, led_b;
   led_state_e        state_a, state_b;

   led_addr_sequencer #(.TICK_DIV(TDIV), .ADDR_LO(12'd0), .ADDR_HI(12'd3)) dut_a (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
      .dir(dir), .bounce(bounce), .rom_data(rom_data_a), .rom_en(rom_en_a),
      .addr(addr_a), .step(step_a), .led(led_a), .busy(busy_a), .state_dbg(state_a)
   );

   led_addr_sequencer #(.TICK_DIV(TDIV), .ADDR_LO(12'd5), .ADDR_HI(12'd5)) dut_b (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
      .dir(dir), .bounce(bounce), .rom_data(rom_data_b), .rom_en(rom_en_b),
      .addr(addr_b), .step(step_b), .led(led_b), .busy(busy_b), .state_dbg(state_b)
   );

   function automatic logic [LED_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [3:0] w;
      w = a[3:0] * 4'd3 + 4'd5;
      return w;
   endfunction

   always @(posedge clk) begin
      rom_data_a <= rom_en_a ? rom_word(addr_a) : 4'h0;
      rom_data_b <= rom_en_b ? rom_word(addr_b) : 4'h0;
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;

   logic [ADDR_W-1:0] exp_q[$];      // expected addr at each step
   int                exp_cyc_q[$];  // cycle index of each expected step
   logic [LED_W-1:0]  led_exp_q[$];  // expected led_a after a step
   int                led_cyc_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, req);
      end
   endtask

   task automatic sb_flush();
      exp_q.delete();
      exp_cyc_q.delete();
      led_exp_q.delete();
      led_cyc_q.delete();
   endtask

   // Per-cycle check: step appears only at scheduled cycles, and led follows 2 cycles later.
   task automatic monitor();
      logic exp_step;
      logic [ADDR_W-1:0] e;
      exp_step = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc_n);
      chk("step_a", 32'(step_a), 32'(exp_step));
      chk("step_b", 32'(step_b), 32'(exp_step));
      if (exp_step) begin
         e = exp_q.pop_front();
         void'(exp_cyc_q.pop_front());
         chk("addr_a_at_step", 32'(addr_a), 32'(e));
         chk("addr_b_at_step", 32'(addr_b), 32'd5);
         led_exp_q.push_back(rom_word(e));
         led_cyc_q.push_back(cyc_n + 2);
      end
      if ((led_cyc_q.size() > 0) && (led_cyc_q[0] == cyc_n)) begin
         chk("led_a", 32'(led_a), 32'(led_exp_q.pop_front()));
         void'(led_cyc_q.pop_front());
         chk("led_b", 32'(led_b), 32'(rom_word(12'd5)));
      end
   endtask

   // One clock: sample #1 after the rising edge, then return so the caller can drive.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc_n++;
      monitor();
   endtask

   task automatic check_idle(input string name);
      chk({name, "_state"}, 32'(state_a), 32'(IDLE));
      chk({name, "_busy"},  32'({busy_a, busy_b}), 32'd0);
      chk({name, "_rom_en"}, 32'({rom_en_a, rom_en_b}), 32'd0);
      chk({name, "_addr_a"}, 32'(addr_a), 32'd0);
      chk({name, "_addr_b"}, 32'(addr_b), 32'd5);
      chk({name, "_led"},    32'({led_a, led_b}), 32'd0);
   endtask

   // Start pulse: schedules n steps TDIV cycles apart, beginning at the sampling edge.
   task automatic do_start(input logic [0:7][3:0] seq, input int n, output int c);
      start = 1'b1;
      c = cyc_n + 1;
      for (int i = 0; i < n; i++) begin
         exp_cyc_q.push_back(c + int'(TDIV) * i);
         exp_q.push_back(12'(seq[i]));
      end
      tick();
      start = 1'b0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic            dir;
      logic            bounce;
      logic [0:7][3:0] seq;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int c;
      vecs[0] = '{dir: 1'b0, bounce: 1'b0, seq: 32'h0123_0123};
      vecs[1] = '{dir: 1'b0, bounce: 1'b1, seq: 32'h0123_2101};
      vecs[2] = '{dir: 1'b1, bounce: 1'b0, seq: 32'h3210_3210};
      vecs[3] = '{dir: 1'b1, bounce: 1'b1, seq: 32'h3210_1232};

      // Reset
      for (int i = 0; i < 3; i++) tick();
      check_idle("reset");
      resetn = 1'b1;
      tick();
      check_idle("post_reset");

      // Table-driven runs: 8 steps each, with a stray start mid-run that must be ignored.
      for (int v = 0; v < 4; v++) begin
         dir    = vecs[v].dir;
         bounce = vecs[v].bounce;
         do_start(vecs[v].seq, 8, c);
         chk("busy_run", 32'({busy_a, rom_en_a, busy_b, rom_en_b}), 32'hF);
         while (cyc_n < c + 30) begin
            start = (cyc_n == c + 8);
            tick();
         end
         start = 1'b0;
         stop = 1'b1;
         tick();
         stop = 1'b0;
         check_idle("stop_vec");
         for (int i = 0; i < 3; i++) tick();
      end

      // Pause for 10 cycles while the prescaler reads 2
      dir = 1'b0;
      bounce = 1'b0;
      exp_q.push_back(12'd0); exp_cyc_q.push_back(cyc_n + 1);
      exp_q.push_back(12'd1); exp_cyc_q.push_back(cyc_n + 5);
      exp_q.push_back(12'd2); exp_cyc_q.push_back(cyc_n + 19);
      exp_q.push_back(12'd3); exp_cyc_q.push_back(cyc_n + 23);
      start = 1'b1;
      c = cyc_n + 1;
      tick();
      start = 1'b0;
      while (cyc_n < c + 6) tick();
      pause = 1'b1;
      while (cyc_n < c + 16) begin
         tick();
         if (cyc_n == c + 12) begin
            chk("hold_state", 32'(state_a), 32'(HOLD));
            chk("hold_addr", 32'(addr_a), 32'd1);
            chk("hold_busy", 32'({busy_a, rom_en_a}), 32'h3);
            chk("hold_led", 32'(led_a), 32'(rom_word(12'd1)));
         end
      end
      pause = 1'b0;
      while (cyc_n < c + 24) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("stop_after_pause");

      // stop and start together in RUN, with a led capture pending
      do_start(32'h0100_0000, 2, c);
      while (cyc_n < c + 4) tick();
      stop = 1'b1;
      start = 1'b1;
      tick();
      stop = 1'b0;
      start = 1'b0;
      sb_flush();
      check_idle("stop_start");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_late_led", 32'({led_a, led_b}), 32'd0);
         chk("stays_idle", 32'(state_a), 32'(IDLE));
      end

      // One-cycle reset mid-RUN
      do_start(32'h0100_0000, 2, c);
      while (cyc_n < c + 5) tick();
      resetn = 1'b0;
      sb_flush();
      tick();
      resetn = 1'b1;
      check_idle("mid_reset");
      for (int i = 0; i < 8; i++) tick();
      check_idle("after_reset_no_restart");
      do_start(32'h0100_0000, 2, c);
      while (cyc_n < c + 6) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("final_stop");

      chk("sched_empty", 32'(exp_q.size() + led_exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
